md_unit: RTL

- Multiply/divide unit in the E stage of the five-stage pipeline.
- Consumes the operands, instruction class and control word that the D/E pipeline register delivers, and owns the architectural HI/LO registers.
- Runs multi-cycle mult/div operations with a busy counter.
- Exposes busy/stall information to the hazard unit, which holds D while a conflicting instruction waits.

---
 rtl/md_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div for a fixed
// number of busy cycles and reports a stall to the hazard unit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [CNT_W-1:0] counter;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;

  logic        is_signed;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] result;
  logic        result_we;

  assign busy     = (counter != '0);
  assign md_stall = start | busy;

  // op_q[0] selects unsigned; the low 64 bits of an extended product are
  // correct for both signed and unsigned operands.
  always_comb begin
    is_signed = ~op_q[0];
    a64       = {{32{a_q[31] & is_signed}}, a_q};
    b64       = {{32{b_q[31] & is_signed}}, b_q};
    prod      = a64 * b64;
  end

  // Signed division via magnitudes so the 0x80000000 / -1 case wraps cleanly.
  always_comb begin
    a_neg = is_signed & a_q[31];
    b_neg = is_signed & b_q[31];
    abs_a = a_neg ? (32'd0 - a_q) : a_q;
    abs_b = b_neg ? (32'd0 - b_q) : b_q;
    div_b = (b_q == 32'd0) ? 32'd1 : abs_b;
    uquot = abs_a / div_b;
    urem  = abs_a % div_b;
    quot  = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    rem   = a_neg ? (32'd0 - urem) : urem;
  end

  always_comb begin
    result    = op_q[1] ? {rem, quot} : prod;
    result_we = ~(op_q[1] && (b_q == 32'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (!busy) begin
      if (start) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= op[1:0];
        counter <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (op == OP_MTHI) begin
        hi <= a;
      end else if (op == OP_MTLO) begin
        lo <= a;
      end
    end else begin
      counter <= counter - 1'b1;
      if (counter == CNT_W'(1) && result_we) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end
    end
  end

endmodule
